// File: rtl/nmea_pkg.sv
// Shared types, ASCII constants and field layout for the RMC sentence parser.
package nmea_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_FIELDS, ST_CK_HI, ST_CK_LO} state_t;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_POINT  = 8'h2E;

    localparam logic [3:0] FLD_TIME   = 4'd1;
    localparam logic [3:0] FLD_STATUS = 4'd2;
    localparam logic [3:0] FLD_LAT    = 4'd3;
    localparam logic [3:0] FLD_NS     = 4'd4;
    localparam logic [3:0] FLD_LON    = 4'd5;
    localparam logic [3:0] FLD_EW     = 4'd6;
    localparam logic [3:0] FLD_DATE   = 4'd9;

    localparam int unsigned TIME_DIGITS = 6;
    localparam int unsigned LAT_DIGITS  = 4;
    localparam int unsigned LON_DIGITS  = 5;
    localparam int unsigned DATE_DIGITS = 6;
    localparam int unsigned FRAC_KEEP   = 4;

    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } hex_t;

    // Letters map to c[3:0] + 9 for both 'A'-'F' and 'a'-'f'.
    function automatic hex_t hex_nibble(input logic [7:0] c);
        hex_t r;
        r.ok  = 1'b1;
        r.val = '0;
        if (c >= "0" && c <= "9")      r.val = c[3:0];
        else if (c >= "A" && c <= "F") r.val = c[3:0] + 4'd9;
        else if (c >= "a" && c <= "f") r.val = c[3:0] + 4'd9;
        else                           r.ok  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/nmea_rmc_parser_if.sv
// UART byte stream in, decoded RMC fix registers and status pulses out.
interface nmea_rmc_parser_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [23:0] utc_time;
    logic [23:0] utc_date;
    logic [31:0] lat_bcd;
    logic        lat_south;
    logic [35:0] lon_bcd;
    logic        lon_west;
    logic        fix_valid;
    logic        out_valid;
    logic        cksum_err;
    logic        fmt_err;

    modport master (output rx_byte, rx_valid,
                    input  utc_time, utc_date, lat_bcd, lat_south, lon_bcd, lon_west,
                           fix_valid, out_valid, cksum_err, fmt_err);
    modport slave  (input  rx_byte, rx_valid,
                    output utc_time, utc_date, lat_bcd, lat_south, lon_bcd, lon_west,
                           fix_valid, out_valid, cksum_err, fmt_err);
endinterface

// File: rtl/nmea_bcd_field.sv
// Accumulates one numeric NMEA field into packed BCD; flags malformed content.
module nmea_bcd_field import nmea_pkg::*; #(
    parameter int unsigned INT_DIGITS  = 6,
    parameter int unsigned FRAC_DIGITS = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear_i,
    input  logic                                  stb_i,
    input  logic [7:0]                            char_i,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0] bcd_o,
    output logic                                  fmt_o
);
    localparam logic [3:0] INT_N  = 4'(INT_DIGITS);
    localparam logic [3:0] FRAC_N = 4'(FRAC_DIGITS);

    logic [4*INT_DIGITS-1:0] int_q, int_d;
    logic [3:0]              icnt_q, icnt_d, fcnt_q, fcnt_d;
    logic                    point_q, point_d, any_q, any_d, bad_q, bad_d;
    logic                    is_digit, frac_wr;

    assign is_digit = (char_i >= "0") && (char_i <= "9");
    assign frac_wr  = stb_i && !clear_i && is_digit && point_q && (fcnt_q < FRAC_N);

    always_comb begin
        int_d = int_q; icnt_d = icnt_q; fcnt_d = fcnt_q;
        point_d = point_q; any_d = any_q; bad_d = bad_q;
        if (clear_i) begin
            int_d = '0; icnt_d = '0; fcnt_d = '0;
            point_d = 1'b0; any_d = 1'b0; bad_d = 1'b0;
        end else if (stb_i) begin
            any_d = 1'b1;
            if (char_i == CH_POINT) begin
                if (point_q) bad_d = 1'b1;
                point_d = 1'b1;
            end else if (!is_digit) begin
                bad_d = 1'b1;
            end else if (!point_q) begin
                if (icnt_q == INT_N) bad_d = 1'b1;
                else begin
                    int_d  = {int_q[4*INT_DIGITS-5:0], char_i[3:0]};
                    icnt_d = icnt_q + 1'b1;
                end
            end else if (frac_wr) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= '0; icnt_q <= '0; fcnt_q <= '0;
            point_q <= 1'b0; any_q <= 1'b0; bad_q <= 1'b0;
        end else begin
            int_q <= int_d; icnt_q <= icnt_d; fcnt_q <= fcnt_d;
            point_q <= point_d; any_q <= any_d; bad_q <= bad_d;
        end
    end

    // Fraction digits fill MSB-first so that missing trailing digits stay zero.
    if (FRAC_DIGITS > 0) begin : g_frac
        logic [4*FRAC_DIGITS-1:0] frac_q, frac_d;
        always_comb begin
            frac_d = frac_q;
            if (clear_i) frac_d = '0;
            else if (frac_wr)
                for (int unsigned k = 0; k < FRAC_DIGITS; k++)
                    if (fcnt_q == 4'(k)) frac_d[4*(FRAC_DIGITS-1-k) +: 4] = char_i[3:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) frac_q <= '0;
            else        frac_q <= frac_d;
        end
        assign bcd_o = {int_q, frac_q};
    end else begin : g_nofrac
        assign bcd_o = int_q;
    end

    assign fmt_o = bad_q | (any_q && (icnt_q != INT_N));

endmodule

// File: rtl/nmea_rmc_parser.sv
// On-the-fly RMC parser: checksum check, BCD conversion, holds last good fix.
module nmea_rmc_parser import nmea_pkg::*; #(
    parameter int unsigned MAX_BYTES = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    nmea_rmc_parser_if.slave   bus
);
    localparam int unsigned    BW   = $clog2(MAX_BYTES + 1);
    localparam logic [BW-1:0]  MAXB = BW'(MAX_BYTES);

    state_t        state_q, state_d;
    logic [7:0]    ck_q, ck_d, ch;
    logic [2:0]    acnt_q, acnt_d;
    logic [3:0]    fld_q, fld_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          fmt_q, fmt_d, seen_q, seen_d;
    logic          fix_q, fix_d, south_q, south_d, west_q, west_d;
    logic          ov_q, ov_d, ce_q, ce_d, fe_q, fe_d;
    hex_t          hi_q, hi_d, hx;
    logic          clr, sel_fmt;
    logic [3:0]    stb, ffmt;
    logic [23:0]   f_time, f_date, time_q, date_q;
    logic [31:0]   f_lat, lat_q;
    logic [35:0]   f_lon, lon_q;
    logic          ofix_q, osouth_q, owest_q;

    assign ch = bus.rx_byte;
    assign hx = hex_nibble(bus.rx_byte);

    always_comb begin
        state_d = state_q; ck_d = ck_q; acnt_d = acnt_q; fld_d = fld_q; bcnt_d = bcnt_q;
        fmt_d = fmt_q; seen_d = seen_q; fix_d = fix_q; south_d = south_q; west_d = west_q;
        hi_d = hi_q; ov_d = 1'b0; ce_d = 1'b0; fe_d = 1'b0; clr = 1'b0; stb = '0;
        case (fld_q)
            FLD_TIME: sel_fmt = ffmt[0];
            FLD_LAT:  sel_fmt = ffmt[1];
            FLD_LON:  sel_fmt = ffmt[2];
            FLD_DATE: sel_fmt = ffmt[3];
            default:  sel_fmt = 1'b0;
        endcase
        if (bus.rx_valid) begin
            if (ch == CH_DOLLAR) begin
                state_d = ST_ADDR; ck_d = '0; acnt_d = '0; fld_d = '0; bcnt_d = BW'(1);
                fmt_d = 1'b0; seen_d = 1'b0; fix_d = 1'b0; south_d = 1'b0; west_d = 1'b0;
                clr = 1'b1;
            end else if (state_q != ST_IDLE) begin
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q >= MAXB) state_d = ST_IDLE;
                else case (state_q)
                    ST_ADDR: begin
                        ck_d = ck_q ^ ch; acnt_d = acnt_q + 1'b1;
                        if ((acnt_q == 3'd2 && ch != "R") || (acnt_q == 3'd3 && ch != "M") ||
                            (acnt_q == 3'd4 && ch != "C")) state_d = ST_IDLE;
                        else if (acnt_q == 3'd4) state_d = ST_FIELDS;
                    end
                    ST_FIELDS: begin
                        if (ch == CH_STAR) begin
                            fmt_d = fmt_q | sel_fmt; state_d = ST_CK_HI;
                        end else begin
                            ck_d = ck_q ^ ch;
                            if (ch == CH_COMMA) begin
                                fmt_d = fmt_q | sel_fmt; seen_d = 1'b0;
                                if (fld_q != 4'hF) fld_d = fld_q + 1'b1;
                            end else case (fld_q)
                                FLD_TIME: stb[0] = 1'b1;
                                FLD_LAT:  stb[1] = 1'b1;
                                FLD_LON:  stb[2] = 1'b1;
                                FLD_DATE: stb[3] = 1'b1;
                                FLD_STATUS, FLD_NS, FLD_EW: begin
                                    seen_d = 1'b1;
                                    if (seen_q) fmt_d = 1'b1;
                                    else if (fld_q == FLD_STATUS) begin
                                        if (ch == "A") fix_d = 1'b1; else if (ch != "V") fmt_d = 1'b1;
                                    end else if (fld_q == FLD_NS) begin
                                        if (ch == "S") south_d = 1'b1; else if (ch != "N") fmt_d = 1'b1;
                                    end else begin
                                        if (ch == "W") west_d = 1'b1; else if (ch != "E") fmt_d = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_CK_HI: begin hi_d = hx; state_d = ST_CK_LO; end
                    ST_CK_LO: begin
                        state_d = ST_IDLE;
                        if (!hi_q.ok || !hx.ok || {hi_q.val, hx.val} != ck_q) ce_d = 1'b1;
                        else if (fmt_q) fe_d = 1'b1;
                        else            ov_d = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; ck_q <= '0; acnt_q <= '0; fld_q <= '0; bcnt_q <= '0;
            fmt_q <= 1'b0; seen_q <= 1'b0; fix_q <= 1'b0; south_q <= 1'b0; west_q <= 1'b0;
            hi_q <= '0; ov_q <= 1'b0; ce_q <= 1'b0; fe_q <= 1'b0;
            time_q <= '0; date_q <= '0; lat_q <= '0; lon_q <= '0;
            ofix_q <= 1'b0; osouth_q <= 1'b0; owest_q <= 1'b0;
        end else begin
            state_q <= state_d; ck_q <= ck_d; acnt_q <= acnt_d; fld_q <= fld_d; bcnt_q <= bcnt_d;
            fmt_q <= fmt_d; seen_q <= seen_d; fix_q <= fix_d; south_q <= south_d; west_q <= west_d;
            hi_q <= hi_d; ov_q <= ov_d; ce_q <= ce_d; fe_q <= fe_d;
            if (ov_d) begin
                time_q <= f_time; date_q <= f_date; lat_q <= f_lat; lon_q <= f_lon;
                ofix_q <= fix_q; osouth_q <= south_q; owest_q <= west_q;
            end
        end
    end

    nmea_bcd_field #(.INT_DIGITS(TIME_DIGITS), .FRAC_DIGITS(0)) u_time (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .stb_i(stb[0]), .char_i(ch),
        .bcd_o(f_time), .fmt_o(ffmt[0]));
    nmea_bcd_field #(.INT_DIGITS(LAT_DIGITS), .FRAC_DIGITS(FRAC_KEEP)) u_lat (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .stb_i(stb[1]), .char_i(ch),
        .bcd_o(f_lat), .fmt_o(ffmt[1]));
    nmea_bcd_field #(.INT_DIGITS(LON_DIGITS), .FRAC_DIGITS(FRAC_KEEP)) u_lon (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .stb_i(stb[2]), .char_i(ch),
        .bcd_o(f_lon), .fmt_o(ffmt[2]));
    nmea_bcd_field #(.INT_DIGITS(DATE_DIGITS), .FRAC_DIGITS(0)) u_date (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .stb_i(stb[3]), .char_i(ch),
        .bcd_o(f_date), .fmt_o(ffmt[3]));

    assign bus.utc_time  = time_q;
    assign bus.utc_date  = date_q;
    assign bus.lat_bcd   = lat_q;
    assign bus.lat_south = osouth_q;
    assign bus.lon_bcd   = lon_q;
    assign bus.lon_west  = owest_q;
    assign bus.fix_valid = ofix_q;
    assign bus.out_valid = ov_q;
    assign bus.cksum_err = ce_q;
    assign bus.fmt_err   = fe_q;

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Directed bench for nmea_rmc_parser: known sentences, hand-derived BCD results.
module tb_nmea_rmc_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nmea_rmc_parser_if bus();
  nmea_rmc_parser #(.MAX_BYTES(128)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  int n_ov = 0, n_ce = 0, n_fe = 0, b_ov = 0, b_ce = 0, b_fe = 0;
  string step = "init";
  logic done = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) n_ov++;
    if (bus.cksum_err === 1'b1) n_ce++;
    if (bus.fmt_err   === 1'b1) n_fe++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic pulses(input int eo, input int ec, input int ef);
    chk("ov_cnt", 64'(n_ov - b_ov), 64'(eo));
    chk("ce_cnt", 64'(n_ce - b_ce), 64'(ec));
    chk("fe_cnt", 64'(n_fe - b_fe), 64'(ef));
  endtask

  task automatic send_str(input string s);
    for (int unsigned i = 0; i < s.len(); i++) begin
      bus.rx_byte  = s[i];
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic mark();
    b_ov = n_ov; b_ce = n_ce; b_fe = n_fe;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic string mk(input string body);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < body.len(); i++) x = x ^ body[i];
    return $sformatf("$%s*%02X", body, x);
  endfunction

  function automatic string pad_to(input string b, input int n, input string c);
    string r;
    r = b;
    while (r.len() < n) r = {r, c};
    return r;
  endfunction

  initial begin
    #1ms;
    if (!done) begin
      errors++;
      $error("FAIL %s/timeout: bench did not complete within the wait limit", step);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  string classic, body_b, body_c, base;

  initial begin
    bus.rx_byte  = '0;
    bus.rx_valid = 1'b0;
    classic = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
    body_b  = "GPRMC,235959.50,A,3351.1234,S,15112.5,W,,,311299,,";
    body_c  = "GNRMC,010203,V,,,,,,,010100,,,N";
    base    = "GPRMC,123519,A,4807.038,N,01131.000,E,,,230394,,";
    idle(3);

    step = "reset";
    chk("utc_time", bus.utc_time, 24'h0);
    chk("utc_date", bus.utc_date, 24'h0);
    chk("lat_bcd", bus.lat_bcd, 32'h0);
    chk("lon_bcd", bus.lon_bcd, 36'h0);
    chk("flags", {bus.lat_south, bus.lon_west, bus.fix_valid}, 3'b000);
    chk("pulses", {bus.out_valid, bus.cksum_err, bus.fmt_err}, 3'b000);
    rst_n = 1'b1;
    idle(2);

    step = "classic";
    mark();
    send_str({"$", classic, "*6A\r\n"});
    idle(3);
    pulses(1, 0, 0);
    chk("utc_time", bus.utc_time, 24'h123519);
    chk("fix_valid", bus.fix_valid, 1'b1);
    chk("lat_bcd", bus.lat_bcd, 32'h48070380);
    chk("lat_south", bus.lat_south, 1'b0);
    chk("lon_bcd", bus.lon_bcd, 36'h011310000);
    chk("lon_west", bus.lon_west, 1'b0);
    chk("utc_date", bus.utc_date, 24'h230394);

    step = "bad_cksum";
    mark();
    send_str({"$", classic, "*6B\r\n"});
    idle(3);
    pulses(0, 1, 0);
    chk("utc_time", bus.utc_time, 24'h123519);
    chk("lat_bcd", bus.lat_bcd, 32'h48070380);

    step = "gga";
    mark();
    send_str({mk("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,"), "\r\n"});
    idle(3);
    pulses(0, 0, 0);
    step = "rmc_b";
    mark();
    send_str({mk(body_b), "\r\n"});
    idle(3);
    pulses(1, 0, 0);
    chk("utc_time", bus.utc_time, 24'h235959);
    chk("lat_bcd", bus.lat_bcd, 32'h33511234);
    chk("lat_south", bus.lat_south, 1'b1);
    chk("lon_bcd", bus.lon_bcd, 36'h151125000);
    chk("lon_west", bus.lon_west, 1'b1);
    chk("utc_date", bus.utc_date, 24'h311299);
    chk("fix_valid", bus.fix_valid, 1'b1);

    step = "bad_lat";
    mark();
    send_str(mk("GPRMC,123519,A,48A7.038,N,01131.000,E,022.4,084.4,230394,003.1,W"));
    idle(3);
    pulses(0, 0, 1);
    chk("lat_bcd", bus.lat_bcd, 32'h33511234);
    chk("utc_time", bus.utc_time, 24'h235959);

    step = "restart";
    mark();
    send_str({"$GPRMC,12", mk(body_c)});
    idle(3);
    pulses(1, 0, 0);
    chk("utc_time", bus.utc_time, 24'h010203);
    chk("fix_valid", bus.fix_valid, 1'b0);
    chk("lat_bcd", bus.lat_bcd, 32'h0);
    chk("lon_bcd", bus.lon_bcd, 36'h0);
    chk("ns_ew", {bus.lat_south, bus.lon_west}, 2'b00);
    chk("utc_date", bus.utc_date, 24'h010100);

    step = "back2back";
    mark();
    send_str({mk(classic), mk(body_b)});
    idle(3);
    pulses(2, 0, 0);
    chk("utc_time", bus.utc_time, 24'h235959);

    step = "reset_mid";
    send_str("$GPRMC,123519,A,48");
    rst_n = 1'b0;
    #1;
    chk("utc_time", bus.utc_time, 24'h0);
    chk("lat_bcd", bus.lat_bcd, 32'h0);
    chk("fix_valid", bus.fix_valid, 1'b0);
    idle(2);
    rst_n = 1'b1;
    mark();
    send_str("07.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n");
    idle(3);
    pulses(0, 0, 0);
    chk("utc_time", bus.utc_time, 24'h0);

    step = "long130";
    mark();
    send_str(pad_to("$GPRMC,", 130, "1"));
    idle(3);
    pulses(0, 0, 0);

    step = "len129";
    mark();
    send_str(mk(pad_to(base, 125, "0")));
    idle(3);
    pulses(0, 0, 0);
    chk("utc_time", bus.utc_time, 24'h0);

    step = "len128";
    mark();
    send_str(mk(pad_to(base, 124, "0")));
    idle(3);
    pulses(1, 0, 0);
    chk("utc_time", bus.utc_time, 24'h123519);
    chk("lon_bcd", bus.lon_bcd, 36'h011310000);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
